// File: rtl/victim_wb_ctrl.sv
// victim_wb_ctrl
// Write-back and flush controller between the victim cache and the memory bus.
// Dirty lines ejected by the victim cache (load side and store side) are queued
// in a write-back FIFO and drained to memory as BUS_STORE. The single memory
// command slot is shared between these write-backs and MSHR fill loads. On halt
// the controller flushes the victim cache, drains the FIFO and raises flush_done.
//
// Optional feature macro: WB_FORWARD_EN
//   defined   : a conflicting MSHR load is served from the youngest matching FIFO
//               entry through mshr_fwd_valid / mshr_fwd_data (no bus command).
//   undefined : a conflicting MSHR load waits until the matching entry drains.
//
// Ports
//   clock, reset        system clock; synchronous active-low reset
//   evict_load_in       victim cache load-side output row {valid,dirty,tag,line_idx,data}
//   evict_store_in      victim cache store-side output row, same layout
//   halt_req            level request for a full flush before halt
//   flush_victim        drives the victim cache flush input
//   flush_done          flush complete, memory coherent
//   wb_full             fewer than 2 free FIFO slots
//   wb_count            FIFO occupancy
//   wb_overflow         sticky; an eviction was dropped
//   mshr_req_valid/addr MSHR load request
//   mshr_req_grant      MSHR load accepted this cycle
//   proc2mem_*          memory command, address, store data
//   mem2proc_response   nonzero = command accepted
module victim_wb_ctrl #(
   parameter int WB_DEPTH     = 8,
   parameter int VC_ENTRIES   = 4,
   parameter int HIGH_WATER   = 6,
   parameter int STARVE_LIMIT = 4,
   parameter int XLEN         = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [XLEN+62:0]  evict_load_in,
   input  logic [XLEN+62:0]  evict_store_in,
   input  logic              halt_req,
   output logic              flush_victim,
   output logic              flush_done,
   output logic              wb_full,
   output logic [$clog2(WB_DEPTH):0] wb_count,
   output logic              wb_overflow,
   input  logic              mshr_req_valid,
   input  logic [XLEN-1:0]   mshr_req_addr,
   output logic              mshr_req_grant,
   output logic [1:0]        proc2mem_command,
   output logic [XLEN-1:0]   proc2mem_addr,
   output logic [63:0]       proc2mem_data,
   input  logic [3:0]        mem2proc_response
`ifdef WB_FORWARD_EN
   ,
   output logic              mshr_fwd_valid,
   output logic [63:0]       mshr_fwd_data
`endif
);

   localparam int PTR_W  = $clog2(WB_DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int LINE_W = XLEN - 3;
   localparam int SCNT_W = $clog2(STARVE_LIMIT + 1);
   localparam int FCNT_W = $clog2(VC_ENTRIES + 1);
   localparam logic [CNT_W-1:0]  DEPTH_C      = CNT_W'(WB_DEPTH);
   localparam logic [CNT_W-1:0]  HIGH_C       = CNT_W'(HIGH_WATER);
   localparam logic [SCNT_W-1:0] STARVE_C     = SCNT_W'(STARVE_LIMIT);
   localparam logic [FCNT_W-1:0] FLUSH_LAST_C = FCNT_W'(VC_ENTRIES - 1);

   // line = {tag, line_idx}; the byte address of a line is {line, 3'b000}
   typedef struct packed {
      logic              valid;
      logic              dirty;
      logic [LINE_W-1:0] line;
      logic [63:0]       data;
   } vc_row_t;

   typedef struct packed {
      logic [LINE_W-1:0] line;
      logic [63:0]       data;
   } wb_entry_t;

   typedef enum logic [1:0] {BUS_NONE = 2'd0, BUS_LOAD = 2'd1, BUS_STORE = 2'd2} bus_cmd_t;
   typedef enum logic [2:0] {IDLE, FLUSH_VC, WAIT_VC, DRAIN, DONE} state_t;

   vc_row_t            ld_row, st_row;
   wb_entry_t          wb_mem [WB_DEPTH];
   wb_entry_t          head;
   logic [PTR_W-1:0]   rd_ptr, wr_ptr;
   logic [CNT_W-1:0]   count, wb_free, avail;
   logic [SCNT_W-1:0]  starve_cnt;
   logic [FCNT_W-1:0]  flush_cnt;
   state_t             state;
   bus_cmd_t           cmd;
   logic               fifo_empty, accepted, conflict, pop;
   logic               ld_ok, st_ok, drop;
   logic [1:0]         n_push;
`ifdef WB_FORWARD_EN
   logic               fwd_grant;
   logic [63:0]        fwd_hit_data;
`endif

   assign ld_row     = evict_load_in;
   assign st_row     = evict_store_in;
   assign head       = wb_mem[rd_ptr];
   assign fifo_empty = (count == '0);
   assign wb_free    = DEPTH_C - count;
   assign accepted   = (mem2proc_response != 4'd0);

   assign wb_count         = count;
   assign wb_full          = (wb_free < CNT_W'(2));
   assign flush_victim     = (state == FLUSH_VC) && (wb_free >= CNT_W'(2));
   assign proc2mem_command = cmd;

   // Conflict search walks oldest to youngest, so the last hit is the youngest.
   // NOTE: every signal written in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      conflict = 1'b0;
`ifdef WB_FORWARD_EN
      fwd_hit_data = '0;
`endif
      for (int i = 0; i < WB_DEPTH; i++) begin
         if ((CNT_W'(i) < count) &&
             (wb_mem[rd_ptr + PTR_W'(i)].line == mshr_req_addr[XLEN-1:3])) begin
            conflict = 1'b1;
`ifdef WB_FORWARD_EN
            fwd_hit_data = wb_mem[rd_ptr + PTR_W'(i)].data;
`endif
         end
      end
   end

   // Command selection; purely a function of registered state and request inputs,
   // so a rejected command reappears unchanged while the inputs hold.
   always_comb begin
      cmd            = BUS_NONE;
      proc2mem_addr  = '0;
      proc2mem_data  = '0;
      mshr_req_grant = 1'b0;
      pop            = 1'b0;
`ifdef WB_FORWARD_EN
      fwd_grant      = 1'b0;
`endif
      unique case (state)
         IDLE: begin
`ifdef WB_FORWARD_EN
            if (!fifo_empty && ((count >= HIGH_C) || (starve_cnt == STARVE_C) || !mshr_req_valid)) begin
`else
            if (!fifo_empty && ((count >= HIGH_C) || (starve_cnt == STARVE_C) || !mshr_req_valid || conflict)) begin
`endif
               cmd           = BUS_STORE;
               proc2mem_addr = {head.line, 3'b000};
               proc2mem_data = head.data;
               pop           = accepted;
`ifdef WB_FORWARD_EN
            end else if (mshr_req_valid && conflict) begin
               // served from the FIFO; the bus slot stays free this cycle
               fwd_grant      = 1'b1;
               mshr_req_grant = 1'b1;
`endif
            end else if (mshr_req_valid) begin
               cmd            = BUS_LOAD;
               proc2mem_addr  = mshr_req_addr;
               mshr_req_grant = accepted;
            end
         end
         FLUSH_VC, WAIT_VC, DRAIN: begin
            if (!fifo_empty) begin
               cmd           = BUS_STORE;
               proc2mem_addr = {head.line, 3'b000};
               proc2mem_data = head.data;
               pop           = accepted;
            end
         end
         default: ;
      endcase
   end

   // Capture: a same-cycle pop frees its slot for a push; load side goes first.
   always_comb begin
      avail  = wb_free + CNT_W'(pop);
      ld_ok  = ld_row.valid && ld_row.dirty && (avail != '0);
      st_ok  = st_row.valid && st_row.dirty &&
               (ld_ok ? (avail >= CNT_W'(2)) : (avail != '0));
      drop   = (ld_row.valid && ld_row.dirty && !ld_ok) ||
               (st_row.valid && st_row.dirty && !st_ok);
      n_push = {1'b0, ld_ok} + {1'b0, st_ok};
   end

   // NOTE: FIFO storage has no reset; occupancy and pointers alone decide which entries are live.
   always_ff @(posedge clock) begin
      if (ld_ok) wb_mem[wr_ptr] <= '{line: ld_row.line, data: ld_row.data};
      if (st_ok) wb_mem[ld_ok ? wr_ptr + PTR_W'(1) : wr_ptr] <= '{line: st_row.line, data: st_row.data};
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock) begin
      if (!reset) begin
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
         starve_cnt  <= '0;
         flush_cnt   <= '0;
         state       <= IDLE;
         wb_overflow <= 1'b0;
         flush_done  <= 1'b0;
`ifdef WB_FORWARD_EN
         mshr_fwd_valid <= 1'b0;
         mshr_fwd_data  <= '0;
`endif
      end else begin
         wr_ptr <= wr_ptr + PTR_W'(n_push);
         rd_ptr <= rd_ptr + PTR_W'(pop);
         count  <= count + CNT_W'(n_push) - CNT_W'(pop);
         if (drop) wb_overflow <= 1'b1;

         if (fifo_empty || pop)
            starve_cnt <= '0;
         else if (mshr_req_grant && (starve_cnt != STARVE_C))
            starve_cnt <= starve_cnt + SCNT_W'(1);

`ifdef WB_FORWARD_EN
         mshr_fwd_valid <= fwd_grant;
         mshr_fwd_data  <= fwd_hit_data;
`endif

         unique case (state)
            IDLE: begin
               flush_cnt <= '0;
               if (halt_req) state <= FLUSH_VC;
            end
            FLUSH_VC: begin
               if (flush_victim) begin
                  flush_cnt <= flush_cnt + FCNT_W'(1);
                  if (flush_cnt == FLUSH_LAST_C) state <= WAIT_VC;
               end
            end
            // the last flushed line appears on the registered victim cache output now
            WAIT_VC: state <= DRAIN;
            DRAIN: begin
               if (fifo_empty && (n_push == 2'd0)) begin
                  state      <= DONE;
                  flush_done <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_victim_wb_ctrl.sv
// Directed testbench for victim_wb_ctrl (default build, WB_FORWARD_EN undefined).
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge.
module tb_victim_wb_ctrl;

   localparam int XLEN = 32;
   localparam logic [1:0] BUS_NONE  = 2'd0;
   localparam logic [1:0] BUS_LOAD  = 2'd1;
   localparam logic [1:0] BUS_STORE = 2'd2;
   localparam logic [XLEN+62:0] NO_ROW = '0;

   logic              clock = 1'b0;
   logic              reset;
   logic [XLEN+62:0]  evict_load_in, evict_store_in;
   logic              halt_req;
   logic              flush_victim, flush_done, wb_full, wb_overflow;
   logic [3:0]        wb_count;
   logic              mshr_req_valid;
   logic [XLEN-1:0]   mshr_req_addr;
   logic              mshr_req_grant;
   logic [1:0]        proc2mem_command;
   logic [XLEN-1:0]   proc2mem_addr;
   logic [63:0]       proc2mem_data;
   logic [3:0]        mem2proc_response;

   int checks   = 0;
   int failures = 0;

   victim_wb_ctrl dut (
      .clock             (clock),
      .reset             (reset),
      .evict_load_in     (evict_load_in),
      .evict_store_in    (evict_store_in),
      .halt_req          (halt_req),
      .flush_victim      (flush_victim),
      .flush_done        (flush_done),
      .wb_full           (wb_full),
      .wb_count          (wb_count),
      .wb_overflow       (wb_overflow),
      .mshr_req_valid    (mshr_req_valid),
      .mshr_req_addr     (mshr_req_addr),
      .mshr_req_grant    (mshr_req_grant),
      .proc2mem_command  (proc2mem_command),
      .proc2mem_addr     (proc2mem_addr),
      .proc2mem_data     (proc2mem_data),
      .mem2proc_response (mem2proc_response)
   );

   always #5 clock = ~clock;

   // {valid, dirty, tag[24:0], line_idx[3:0], data[63:0]}
   function automatic logic [XLEN+62:0] make_row(input logic [24:0] tag, input logic [3:0] idx,
                                                 input logic [63:0] data, input logic dirty);
      return {1'b1, dirty, tag, idx, data};
   endfunction

   task automatic next_cycle();
      @(posedge clock);
      #1;
   endtask

   task automatic sample();
      @(negedge clock);
   endtask

   task automatic test_reset();
      reset = 1'b0; halt_req = 1'b1; mshr_req_valid = 1'b0; mshr_req_addr = '0;
      evict_load_in = NO_ROW; evict_store_in = NO_ROW; mem2proc_response = 4'd0;
      repeat (3) next_cycle();
      sample();
      checks++; if (wb_count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", wb_count); end
      checks++; if (proc2mem_command !== BUS_NONE) begin failures++; $display("FAIL reset_cmd got=%0d exp=0", proc2mem_command); end
      checks++; if ({flush_victim, flush_done, wb_full, wb_overflow, mshr_req_grant} !== 5'b0)
         begin failures++; $display("FAIL reset_flags got=%b exp=00000", {flush_victim, flush_done, wb_full, wb_overflow, mshr_req_grant}); end
      checks++; if ({proc2mem_addr, proc2mem_data} !== '0) begin failures++; $display("FAIL reset_bus got=%h/%h exp=0", proc2mem_addr, proc2mem_data); end
      next_cycle();
      reset = 1'b1; halt_req = 1'b0;
      repeat (2) next_cycle();
      sample();
      checks++; if (flush_victim !== 1'b0) begin failures++; $display("FAIL reset_idle flush_victim got=%b exp=0", flush_victim); end
   endtask

   task automatic test_dual_capture();
      next_cycle();
      mem2proc_response = 4'd1;
      evict_load_in  = make_row(25'h12, 4'h3, 64'hAAAA_0001, 1'b1);
      evict_store_in = make_row(25'h40, 4'h5, 64'hBBBB_0002, 1'b1);
      sample();
      checks++; if (wb_count !== 4'd0) begin failures++; $display("FAIL dual_pre_count got=%0d exp=0", wb_count); end
      next_cycle();
      evict_load_in = NO_ROW; evict_store_in = NO_ROW;
      sample();
      checks++; if (wb_count !== 4'd2) begin failures++; $display("FAIL dual_count2 got=%0d exp=2", wb_count); end
      checks++; if (proc2mem_command !== BUS_STORE || proc2mem_addr !== 32'h0000_0918 || proc2mem_data !== 64'hAAAA_0001)
         begin failures++; $display("FAIL dual_first got=%0d %h %h exp=2 00000918 aaaa0001", proc2mem_command, proc2mem_addr, proc2mem_data); end
      next_cycle();
      sample();
      checks++; if (wb_count !== 4'd1) begin failures++; $display("FAIL dual_count1 got=%0d exp=1", wb_count); end
      checks++; if (proc2mem_command !== BUS_STORE || proc2mem_addr !== 32'h0000_2028 || proc2mem_data !== 64'hBBBB_0002)
         begin failures++; $display("FAIL dual_second got=%0d %h %h exp=2 00002028 bbbb0002", proc2mem_command, proc2mem_addr, proc2mem_data); end
      next_cycle();
      sample();
      checks++; if (wb_count !== 4'd0 || proc2mem_command !== BUS_NONE)
         begin failures++; $display("FAIL dual_empty got=%0d cmd=%0d exp=0 cmd=0", wb_count, proc2mem_command); end
   endtask

   task automatic test_starvation();
      next_cycle();
      evict_load_in = make_row(25'h7, 4'h1, 64'h7777, 1'b1);
      next_cycle();
      evict_load_in = NO_ROW;
      mshr_req_valid = 1'b1; mshr_req_addr = 32'h0001_0000;
      for (int i = 0; i < 4; i++) begin
         sample();
         checks++; if (proc2mem_command !== BUS_LOAD || mshr_req_grant !== 1'b1 || proc2mem_addr !== 32'h0001_0000)
            begin failures++; $display("FAIL starve_load%0d got=%0d g=%b %h exp=1 g=1 00010000", i, proc2mem_command, mshr_req_grant, proc2mem_addr); end
         next_cycle();
      end
      sample();
      checks++; if (proc2mem_command !== BUS_STORE || mshr_req_grant !== 1'b0 || proc2mem_addr !== 32'h0000_0388)
         begin failures++; $display("FAIL starve_store got=%0d g=%b %h exp=2 g=0 00000388", proc2mem_command, mshr_req_grant, proc2mem_addr); end
      next_cycle();
      sample();
      checks++; if (proc2mem_command !== BUS_LOAD || mshr_req_grant !== 1'b1 || wb_count !== 4'd0)
         begin failures++; $display("FAIL starve_resume got=%0d g=%b n=%0d exp=1 g=1 n=0", proc2mem_command, mshr_req_grant, wb_count); end
      next_cycle();
      mshr_req_valid = 1'b0;
      sample();
   endtask

   task automatic test_conflict();
      next_cycle();
      evict_load_in = make_row(25'h1, 4'h0, 64'hC0FFEE, 1'b1);
      next_cycle();
      evict_load_in = NO_ROW;
      mshr_req_valid = 1'b1; mshr_req_addr = 32'h0000_0084; mem2proc_response = 4'd0;
      sample();
      checks++; if (proc2mem_command !== BUS_STORE || proc2mem_addr !== 32'h0000_0080 || mshr_req_grant !== 1'b0)
         begin failures++; $display("FAIL conflict_store got=%0d %h g=%b exp=2 00000080 g=0", proc2mem_command, proc2mem_addr, mshr_req_grant); end
      next_cycle();
      mem2proc_response = 4'd1;
      sample();
      checks++; if (proc2mem_command !== BUS_STORE || proc2mem_addr !== 32'h0000_0080 || wb_count !== 4'd1)
         begin failures++; $display("FAIL conflict_retry got=%0d %h n=%0d exp=2 00000080 n=1", proc2mem_command, proc2mem_addr, wb_count); end
      next_cycle();
      sample();
      checks++; if (proc2mem_command !== BUS_LOAD || proc2mem_addr !== 32'h0000_0084 || mshr_req_grant !== 1'b1)
         begin failures++; $display("FAIL conflict_load got=%0d %h g=%b exp=1 00000084 g=1", proc2mem_command, proc2mem_addr, mshr_req_grant); end
      next_cycle();
      mshr_req_valid = 1'b0;
      sample();
   endtask

   task automatic test_flush();
      logic [XLEN+62:0] vc [4];
      logic [XLEN-1:0]  exp_addr [3];
      logic [XLEN-1:0]  got_addr [3];
      logic [XLEN+62:0] pending;
      int vc_idx, fv, stores, granted;
      bit done;
      vc[0] = make_row(25'h21, 4'h2, 64'hF0, 1'b1);
      vc[1] = make_row(25'h22, 4'h6, 64'hF1, 1'b0);
      vc[2] = make_row(25'h23, 4'h9, 64'hF2, 1'b1);
      vc[3] = make_row(25'h24, 4'hF, 64'hF3, 1'b1);
      exp_addr[0] = 32'h0000_1090; exp_addr[1] = 32'h0000_11C8; exp_addr[2] = 32'h0000_1278;
      got_addr[0] = '0; got_addr[1] = '0; got_addr[2] = '0;
      pending = NO_ROW; vc_idx = 0; fv = 0; stores = 0; granted = 0; done = 1'b0;
      next_cycle();
      halt_req = 1'b1; mem2proc_response = 4'd1; mshr_req_valid = 1'b0;
      sample();
      checks++; if (flush_victim !== 1'b0) begin failures++; $display("FAIL flush_idle_cycle got=%b exp=0", flush_victim); end
      for (int cyc = 0; cyc < 40 && !done; cyc++) begin
         next_cycle();
         evict_load_in = pending;
         mshr_req_valid = 1'b1; mshr_req_addr = 32'h0000_4000;
         sample();
         if (flush_done === 1'b1) done = 1'b1;
         else begin
            if (mshr_req_grant === 1'b1) granted++;
            if (proc2mem_command === BUS_STORE) begin
               if (stores < 3) got_addr[stores] = proc2mem_addr;
               stores++;
            end
            if (flush_victim === 1'b1) begin
               pending = (vc_idx < 4) ? vc[vc_idx] : NO_ROW;
               vc_idx++; fv++;
            end else pending = NO_ROW;
         end
      end
      checks++; if (!done) begin failures++; $display("FAIL flush_timeout flush_done not seen within 40 cycles"); end
      checks++; if (fv != 4) begin failures++; $display("FAIL flush_victim_cycles got=%0d exp=4", fv); end
      checks++; if (stores != 3) begin failures++; $display("FAIL flush_stores got=%0d exp=3", stores); end
      for (int i = 0; i < 3; i++) begin
         checks++; if (got_addr[i] !== exp_addr[i]) begin failures++; $display("FAIL flush_addr%0d got=%h exp=%h", i, got_addr[i], exp_addr[i]); end
      end
      checks++; if (granted != 0) begin failures++; $display("FAIL flush_mshr_grants got=%0d exp=0", granted); end
      checks++; if (wb_count !== 4'd0) begin failures++; $display("FAIL flush_count got=%0d exp=0", wb_count); end
      next_cycle();
      halt_req = 1'b0;
      next_cycle();
      sample();
      checks++; if (flush_done !== 1'b1 || proc2mem_command !== BUS_NONE || mshr_req_grant !== 1'b0)
         begin failures++; $display("FAIL done_hold got=%b cmd=%0d g=%b exp=1 cmd=0 g=0", flush_done, proc2mem_command, mshr_req_grant); end
      mshr_req_valid = 1'b0;
   endtask

   task automatic test_backpressure();
      next_cycle();
      reset = 1'b0; mem2proc_response = 4'd0; evict_load_in = NO_ROW; evict_store_in = NO_ROW;
      next_cycle();
      reset = 1'b1;
      sample();
      checks++; if (flush_done !== 1'b0 || wb_count !== 4'd0) begin failures++; $display("FAIL bp_reset got=%b n=%0d exp=0 n=0", flush_done, wb_count); end
      for (int i = 0; i < 3; i++) begin
         next_cycle();
         evict_load_in  = make_row(25'h30 + 25'(2 * i), 4'h0, 64'(i), 1'b1);
         evict_store_in = make_row(25'h31 + 25'(2 * i), 4'h0, 64'(i), 1'b1);
      end
      next_cycle();
      evict_load_in = make_row(25'h36, 4'h0, 64'h6, 1'b1); evict_store_in = NO_ROW;
      sample();
      checks++; if (wb_count !== 4'd6 || wb_full !== 1'b0) begin failures++; $display("FAIL bp_six got=%0d full=%b exp=6 full=0", wb_count, wb_full); end
      next_cycle();
      evict_load_in = NO_ROW; halt_req = 1'b1;
      sample();
      checks++; if (wb_count !== 4'd7 || wb_full !== 1'b1) begin failures++; $display("FAIL bp_seven got=%0d full=%b exp=7 full=1", wb_count, wb_full); end
      checks++; if (proc2mem_command !== BUS_STORE || proc2mem_addr !== 32'h0000_1800)
         begin failures++; $display("FAIL bp_head got=%0d %h exp=2 00001800", proc2mem_command, proc2mem_addr); end
      next_cycle();
      sample();
      checks++; if (flush_victim !== 1'b0) begin failures++; $display("FAIL bp_stall got=%b exp=0", flush_victim); end
      next_cycle();
      evict_load_in  = make_row(25'h37, 4'h0, 64'h7, 1'b1);
      evict_store_in = make_row(25'h38, 4'h0, 64'h8, 1'b1);
      sample();
      checks++; if (wb_overflow !== 1'b0) begin failures++; $display("FAIL bp_no_overflow_yet got=%b exp=0", wb_overflow); end
      next_cycle();
      evict_load_in = NO_ROW; evict_store_in = NO_ROW;
      sample();
      checks++; if (wb_count !== 4'd8 || wb_overflow !== 1'b1) begin failures++; $display("FAIL bp_overflow got=%0d ovf=%b exp=8 ovf=1", wb_count, wb_overflow); end
      checks++; if (flush_victim !== 1'b0 || flush_done !== 1'b0) begin failures++; $display("FAIL bp_flush_stalled got=%b done=%b exp=0 done=0", flush_victim, flush_done); end
      next_cycle();
      sample();
      checks++; if (wb_overflow !== 1'b1 || proc2mem_addr !== 32'h0000_1800)
         begin failures++; $display("FAIL bp_sticky got=%b %h exp=1 00001800", wb_overflow, proc2mem_addr); end
      next_cycle();
      reset = 1'b0; halt_req = 1'b0;
      next_cycle();
      reset = 1'b1;
      sample();
      checks++; if (wb_count !== 4'd0 || wb_overflow !== 1'b0 || proc2mem_command !== BUS_NONE || flush_victim !== 1'b0)
         begin failures++; $display("FAIL bp_reset_midflush got=%0d ovf=%b cmd=%0d fv=%b exp=0 0 0 0", wb_count, wb_overflow, proc2mem_command, flush_victim); end
   endtask

   initial begin
      test_reset();
      test_dual_capture();
      test_starvation();
      test_conflict();
      test_flush();
      test_backpressure();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/victim_wb_ctrl.md
Name: victim_wb_ctrl

Overview:
- Write-back and flush controller between the victim cache and the memory bus.
- Captures dirty lines the victim cache ejects (load-side and store-side outputs) into a write-back FIFO and drains them to memory as BUS_STORE.
- Arbitrates the single memory command slot between these write-backs and MSHR fill loads.
- On halt, drives the victim cache's flush_victim input until every dirty line has been pushed out, then drains the FIFO and reports flush_done.

Parameters:
WB_DEPTH, 8, write-back FIFO entries (power of 2, >=4)
VC_ENTRIES, 4, victim cache entries; one dirty line is flushed per flush cycle
HIGH_WATER, 6, FIFO occupancy at or above which write-back beats MSHR
STARVE_LIMIT, 4, consecutive MSHR grants allowed while FIFO non-empty

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-low reset (0 = reset)
evict_load_in  in  $bits(VICTIM_CACHE_ROW)  victim cache load_victim_cache_out[0]
evict_store_in  in  $bits(VICTIM_CACHE_ROW)  victim cache store_victim_cache_out[0]
halt_req  in  1  level; request full flush before halt
flush_victim  out  1  to victim cache flush input
flush_done  out  1  flush complete, memory coherent
wb_full  out  1  fewer than 2 free FIFO slots; dcache must stall evictions
wb_count  out  $clog2(WB_DEPTH)+1  FIFO occupancy
wb_overflow  out  1  sticky; an eviction was dropped
mshr_req_valid  in  1  MSHR load request
mshr_req_addr  in  XLEN  MSHR load address
mshr_req_grant  out  1  MSHR load accepted by memory this cycle
proc2mem_command  out  2  BUS_NONE/BUS_LOAD/BUS_STORE
proc2mem_addr  out  XLEN  memory address
proc2mem_data  out  64  store data
mem2proc_response  in  4  nonzero = command accepted

Behaviour:
- Reset (reset==0 at posedge): FIFO empty, state IDLE, starve counter 0, wb_overflow 0. All outputs 0; proc2mem_command = BUS_NONE.
- Capture: at a posedge, each evict input with valid&&dirty pushes {tag,line_idx,data}. If both are valid, load-side is pushed first, then store-side. An entry is issuable the next cycle. A push that finds the FIFO full is dropped and sets wb_overflow.
- Store address: {tag, line_idx, 3'b000}.
- Bus outputs are combinational from registered state plus request inputs.
- Arbitration (IDLE):
  - A write-back is chosen when the FIFO is non-empty and any of these holds: wb_count >= HIGH_WATER; starve counter == STARVE_LIMIT; mshr_req_valid==0; or the MSHR line address [XLEN-1:3] matches any valid FIFO entry (conflict).
  - Otherwise the MSHR is chosen: BUS_LOAD with mshr_req_addr.
  - Acceptance: the command is accepted when mem2proc_response != 0.
    - Accepted store: FIFO pops.
    - Accepted load: mshr_req_grant=1 in the same cycle.
  - Starve counter:
    - Increments on each accepted MSHR grant while the FIFO is non-empty.
    - Clears on an accepted store or when the FIFO is empty.
    - Saturates at STARVE_LIMIT.
  - A rejected command is re-presented unchanged the next cycle. Choice is recomputed only if inputs change.
- Push and pop in the same cycle are legal; occupancy is unchanged.
- State machine:
  - IDLE -> FLUSH_VC when halt_req==1.
  - FLUSH_VC:
    - flush_victim=1 only when at least 2 FIFO slots are free.
    - A counter increments on each cycle flush_victim=1.
    - After VC_ENTRIES such cycles, wait 1 cycle (victim cache output is registered), then go to DRAIN.
    - MSHR never granted; FIFO drains concurrently.
  - DRAIN: issue stores only. Go to DONE when the FIFO is empty and no store is pending.
  - DONE: flush_done=1, proc2mem_command=BUS_NONE. Held until reset; halt_req is ignored.
- Deasserting halt_req after leaving IDLE has no effect.
- Reset mid-flush returns to IDLE and discards the FIFO.

Optional Feature:
WB_FORWARD_EN
- Defined: an MSHR request that conflicts with a FIFO entry is not blocked.
  - mshr_req_grant=1 with no bus command issued that cycle.
  - Next cycle, mshr_fwd_valid=1 and mshr_fwd_data (64b, extra outputs) carry the youngest matching entry.
  - The entry stays in the FIFO and is written back later.
- Undefined: a conflict forces write-back priority until the matching entry drains. mshr_fwd_* ports are absent.

Test Plan:
- Reset: hold reset=0 for 3 cycles with halt_req=1 -> all outputs 0, BUS_NONE, wb_count=0; still in IDLE after release only if halt_req=0.
- Dual capture: same cycle, load tag=0x12 idx=3 dirty and store tag=0x40 idx=5 dirty, memory always accepts -> next cycles BUS_STORE addr {0x12,3,000} then {0x40,5,000}; wb_count 2->1->0.
- Starvation: 1 FIFO entry, mshr_req_valid held, non-conflicting -> 4 BUS_LOAD grants, then 1 BUS_STORE, then loads resume.
- Conflict: FIFO holds line 0x80; MSHR requests 0x84 -> store of 0x80 issued first, MSHR granted the following cycle (without WB_FORWARD_EN).
- Flush: 3 dirty lines in the victim cache, halt_req=1 -> flush_victim high 4 cycles, 3 BUS_STORE, flush_done=1, MSHR never granted.
- Backpressure: memory rejects all commands; push 7 entries -> wb_full=1 at 7; flush_victim stalls in FLUSH_VC; 9th push sets wb_overflow.
